mux_scan_ctrl: RTL

//  Upstream driver for mux_16x1. Accepts a 16-bit word on a start handshake and holds it on the mux data bus.

---
 rtl/mux_scan_ctrl_pkg.sv | 14 +
 rtl/mux_16x1.sv | 10 +
 rtl/mux_scan_ctrl_step_timer.sv | 31 +++
 rtl/mux_scan_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and defaults for the mux scan controller.
package mux_scan_ctrl_pkg;

  // Default select width; data width is 2**SEL_W.
  localparam int unsigned DEF_SEL_W = 4;

  // Controller state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/mux_16x1.sv
// Combinational 16:1 multiplexer; the device under self-check.
module mux_16x1 (
  input  logic [15:0] data,
  input  logic [3:0]  select,
  output logic        y
);

  assign y = data[select];

endmodule

// File: rtl/mux_scan_ctrl_step_timer.sv
// Step timer: counts 0..CYCLES-1 while enabled, flags the last cycle of each step.
module mux_scan_ctrl_step_timer #(
  parameter int unsigned CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick_c
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Last-cycle flag, only meaningful while counting.
  assign o_tick_c = i_enable && (r_cnt == LAST);

  // Step counter; wraps to zero after the last cycle of a step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Drives a 16:1 mux through every select value, serialises the sampled
// outputs and checks the reassembled word against the loaded one.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int unsigned SEL_W       = DEF_SEL_W,
  parameter int unsigned STEP_CYCLES = 1,
  localparam int unsigned WIDTH      = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] word_in,
  output logic             ready,
  output logic [WIDTH-1:0] data,
  output logic [SEL_W-1:0] select,
  input  logic             y,
  output logic             ser_valid,
  output logic             ser_bit,
  output logic [WIDTH-1:0] word_out,
  output logic             done,
  output logic             match
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);

  scan_state_e      r_state;
  logic             r_ready;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_select;
  logic [WIDTH-1:0] r_word;
  logic             r_ser_valid;
  logic             r_ser_bit;
  logic             r_done;
  logic             r_match;

  logic             w_accept;
  logic             w_tick;
  logic             w_last_sel;
  logic [WIDTH-1:0] w_next_word;

  assign w_accept   = start && r_ready;
  assign w_last_sel = (r_select == SEL_LAST);

  // Per-step timing; restarts on every accepted scan.
  mux_scan_ctrl_step_timer #(
    .CYCLES (STEP_CYCLES)
  ) u_step_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_accept),
    .i_enable (r_state == ST_SCAN),
    .o_tick_c (w_tick)
  );

  // Word with the current sample merged in at the current select position.
  always_comb begin
    w_next_word           = r_word;
    w_next_word[r_select] = y;
  end

  // Scan FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b1;
      r_data      <= '0;
      r_select    <= '0;
      r_word      <= '0;
      r_ser_valid <= 1'b0;
      r_ser_bit   <= 1'b0;
      r_done      <= 1'b0;
      r_match     <= 1'b0;
    end else begin
      r_ser_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_data   <= word_in;
            r_word   <= '0;
            r_select <= '0;
            r_match  <= 1'b0;
            r_ready  <= 1'b0;
            r_state  <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_tick) begin
            r_word      <= w_next_word;
            r_ser_bit   <= y;
            r_ser_valid <= 1'b1;
            if (w_last_sel) begin
              r_done  <= 1'b1;
              r_match <= (w_next_word == r_data);
              r_state <= ST_DONE;
            end else begin
              r_select <= r_select + SEL_W'(1);
            end
          end
        end
        ST_DONE: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign data      = r_data;
  assign select    = r_select;
  assign word_out  = r_word;
  assign ser_valid = r_ser_valid;
  assign ser_bit   = r_ser_bit;
  assign done      = r_done;
  assign match     = r_match;

endmodule
